// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer.
// One shift-add (MUL) or restoring-subtract (DIV) step per RUN cycle, using an
// external add_sub of width DATA_WIDTH+2 reached through the o_as_*/i_as_s ports.
// Working registers are shared between operations:
//   hi = product high half / partial remainder
//   lo = multiplier shifting out, product low half / quotient
//   m  = multiplicand / divisor
module muldiv_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_res_lo,
    output logic [DATA_WIDTH-1:0] o_res_hi,
    output logic                  o_div_zero,
    output logic [DATA_WIDTH+1:0] o_as_x,
    output logic [DATA_WIDTH+1:0] o_as_y,
    output logic                  o_as_cin,
    input  logic [DATA_WIDTH+1:0] i_as_s
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic            op;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    hi;
    logic [W-1:0]    lo;
    logic [W-1:0]    m;

    logic [W:0]      sh;
    logic [W:0]      mul_sum;
    logic [W-1:0]    hi_nx;
    logic [W-1:0]    lo_nx;

    // Adder operand steering and next-step values of the working registers
    always_comb begin
        o_as_x   = '0;
        o_as_y   = '0;
        o_as_cin = 1'b0;
        sh       = {hi, lo[W-1]};
        mul_sum  = lo[0] ? i_as_s[W:0] : {1'b0, hi};
        hi_nx    = hi;
        lo_nx    = lo;
        if (state == RUN) begin
            if (!op) begin
                o_as_x = {2'b00, hi};
                o_as_y = {2'b00, m};
                hi_nx  = mul_sum[W:1];
                lo_nx  = {mul_sum[0], lo[W-1:1]};
            end else begin
                o_as_cin = 1'b1;
                o_as_x   = {1'b0, sh};
                o_as_y   = {2'b00, m};
                // Sign bit of the trial subtraction decides restore vs. keep
                if (!i_as_s[W+1]) begin
                    hi_nx = i_as_s[W-1:0];
                    lo_nx = {lo[W-2:0], 1'b1};
                end else begin
                    hi_nx = sh[W-1:0];
                    lo_nx = {lo[W-2:0], 1'b0};
                end
            end
        end
    end

    // Sequencer FSM with registered status and result outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            op         <= 1'b0;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            m          <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_res_lo   <= '0;
            o_res_hi   <= '0;
            o_div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        op     <= i_op;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        if (i_op && (i_b == '0)) begin
                            o_res_lo   <= '1;
                            o_res_hi   <= i_a;
                            o_div_zero <= 1'b1;
                            o_done     <= 1'b1;
                            state      <= DONE;
                        end else begin
                            hi    <= '0;
                            lo    <= i_op ? i_a : i_b;
                            m     <= i_op ? i_b : i_a;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    hi  <= hi_nx;
                    lo  <= lo_nx;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Capture the values produced by this final step
                        o_res_lo   <= lo_nx;
                        o_res_hi   <= hi_nx;
                        o_div_zero <= 1'b0;
                        o_done     <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: behavioural add_sub, arithmetic reference model.
module tb_muldiv_seq;

    localparam int W  = 32;
    localparam int AW = W + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy, done, dz;
    logic [W-1:0]  res_lo, res_hi;
    logic [AW-1:0] as_x, as_y, as_s;
    logic          as_cin;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] rlo, rhi, elo, ehi;
    logic         rdz, edz;
    int           lat, elat;

    muldiv_seq #(.DATA_WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
        .i_a(a), .i_b(b), .o_busy(busy), .o_done(done),
        .o_res_lo(res_lo), .o_res_hi(res_hi), .o_div_zero(dz),
        .o_as_x(as_x), .o_as_y(as_y), .o_as_cin(as_cin), .i_as_s(as_s)
    );

    // External add_sub
    assign as_s = as_x + (as_y ^ {AW{as_cin}}) + AW'(as_cin);

    always #5 clk = ~clk;

    function automatic void model(input logic mop, input logic [W-1:0] ma, mb,
                                  output logic [W-1:0] mlo, mhi, output logic mdz,
                                  output int mlat);
        logic [2*W-1:0] p;
        if (!mop) begin
            p = {{W{1'b0}}, ma} * {{W{1'b0}}, mb};
            mlo = p[W-1:0]; mhi = p[2*W-1:W]; mdz = 1'b0; mlat = W + 1;
        end else if (mb == '0) begin
            mlo = '1; mhi = ma; mdz = 1'b1; mlat = 1;
        end else begin
            mlo = ma / mb; mhi = ma % mb; mdz = 1'b0; mlat = W + 1;
        end
    endfunction

    // Issue one operation and wait (bounded) for o_done; lat counts cycles after start
    task automatic run_op(input logic iop, input logic [W-1:0] ia, ib);
        @(negedge clk);
        start = 1'b1; op = iop; a = ia; b = ib;
        @(negedge clk);
        start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
        lat = -1;
        for (int k = 1; k <= W + 6; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        rlo = res_lo; rhi = res_hi; rdz = dz;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, dz, res_lo, res_hi, as_x, as_y, as_cin} !== '0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b dz=%b lo=%h hi=%h x=%h y=%h cin=%b, expected all 0",
                     busy, done, dz, res_lo, res_hi, as_x, as_y, as_cin);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mul_max();
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tests++;
        if ({rhi, rlo} !== 64'hFFFF_FFFE_0000_0001) begin
            fails++;
            $display("FAIL mul_max: got %h_%h, expected fffffffe_00000001", rhi, rlo);
        end
        tests++;
        if (lat !== W + 1) begin
            fails++;
            $display("FAIL mul_max_latency: got %0d, expected %0d", lat, W + 1);
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL mul_return_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_div();
        run_op(1'b1, 32'd100, 32'd7);
        tests++;
        if (rlo !== 32'd14 || rhi !== 32'd2 || rdz !== 1'b0 || lat !== W + 1) begin
            fails++;
            $display("FAIL div_100_7: got q=%0d r=%0d dz=%b lat=%0d, expected 14 2 0 %0d",
                     rlo, rhi, rdz, lat, W + 1);
        end
        run_op(1'b1, 32'hFFFF_FFFF, 32'd1);
        tests++;
        if (rlo !== 32'hFFFF_FFFF || rhi !== 32'h0 || rdz !== 1'b0) begin
            fails++;
            $display("FAIL div_max_1: got q=%h r=%h dz=%b, expected ffffffff 0 0", rlo, rhi, rdz);
        end
    endtask

    task automatic test_div_zero();
        run_op(1'b1, 32'h1234, 32'h0);
        tests++;
        if (rlo !== 32'hFFFF_FFFF || rhi !== 32'h1234 || rdz !== 1'b1) begin
            fails++;
            $display("FAIL div_zero: got q=%h r=%h dz=%b, expected ffffffff 1234 1", rlo, rhi, rdz);
        end
        tests++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL div_zero_latency: got %0d, expected 1", lat);
        end
        tests++;
        if (as_x !== '0 || as_y !== '0 || as_cin !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL div_zero_ports: x=%h y=%h cin=%b busy=%b, expected 0 0 0 1",
                     as_x, as_y, as_cin, busy);
        end
    endtask

    task automatic test_mul_small();
        run_op(1'b0, 32'h0, 32'hABCD);
        tests++;
        if ({rhi, rlo, rdz} !== {64'h0, 1'b0}) begin
            fails++;
            $display("FAIL mul_zero: got %h_%h dz=%b, expected 0_0 0", rhi, rlo, rdz);
        end
        run_op(1'b0, 32'd7, 32'd1);
        tests++;
        if ({rhi, rlo} !== 64'd7) begin
            fails++;
            $display("FAIL mul_7_1: got %h_%h, expected 0_7", rhi, rlo);
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int dlat;
        ndone = 0; dlat = -1;
        model(1'b0, 32'h0001_2345, 32'h0000_6789, elo, ehi, edz, elat);
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'h0001_2345; b = 32'h0000_6789;
        for (int k = 1; k <= W + 10; k++) begin
            @(negedge clk);
            if (k == 5) begin
                start = 1'b1; op = 1'b1; a = 32'hDEAD_BEEF; b = 32'h3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                dlat = k;
                rlo = res_lo; rhi = res_hi;
            end
        end
        start = 1'b0;
        tests++;
        if (ndone !== 1 || dlat !== elat) begin
            fails++;
            $display("FAIL ignore_start_done: got %0d pulses at %0d, expected 1 at %0d", ndone, dlat, elat);
        end
        tests++;
        if (rlo !== elo || rhi !== ehi) begin
            fails++;
            $display("FAIL ignore_start_result: got %h_%h, expected %h_%h", rhi, rlo, ehi, elo);
        end
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        ndone = 0;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'h1234; b = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 10; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, dz, res_lo, res_hi, as_x, as_y, as_cin} !== '0) begin
            fails++;
            $display("FAIL reset_mid_run: busy=%b done=%b dz=%b lo=%h hi=%h x=%h, expected all 0",
                     busy, done, dz, res_lo, res_hi, as_x);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        tests++;
        if (ndone !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: got %0d done pulses busy=%b, expected 0 0", ndone, busy);
        end
        run_op(1'b0, 32'd6, 32'd7);
        tests++;
        if (rlo !== 32'd42 || rhi !== 32'd0 || lat !== W + 1) begin
            fails++;
            $display("FAIL restart_6x7: got %h_%h lat=%0d, expected 0_2a lat=%0d", rhi, rlo, lat, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic         rop;
        logic [W-1:0] ra, rb;
        for (int i = 0; i < 512; i++) begin
            rop = 1'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = W'($urandom_range(1, 15));
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = ra >> $urandom_range(0, 31);
            model(rop, ra, rb, elo, ehi, edz, elat);
            run_op(rop, ra, rb);
            tests++;
            if (rlo !== elo || rhi !== ehi || rdz !== edz || lat !== elat) begin
                fails++;
                $display("FAIL random[%0d] op=%b a=%h b=%h: got lo=%h hi=%h dz=%b lat=%0d, expected %h %h %b %0d",
                         i, rop, ra, rb, rlo, rhi, rdz, lat, elo, ehi, edz, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_max();
        test_div();
        test_div_zero();
        test_mul_small();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
